// File: rtl/res_arb_pkg.sv
// Shared types and constants for the result-RAM arbiter.
package res_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  localparam int DEF_AW = 14;
  localparam int DEF_DW = 8;

endpackage

// File: rtl/res_arb_rdtag.sv
// Read-return tagging: tracks in-flight reads for RD_LAT cycles and steers
// the RAM read data to the port that issued each read.
module res_arb_rdtag
  import res_arb_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_vld,
  input  logic          issue_port,
  input  logic [DW-1:0] res_di,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata
);

  logic [RD_LAT-1:0] tag_vld_p;
  logic [RD_LAT-1:0] tag_port_p;
  logic              ret_vld;
  logic              ret_port;

  assign ret_vld  = tag_vld_p[RD_LAT-1];
  assign ret_port = tag_port_p[RD_LAT-1];

  // Tag pipeline: stage 0 lines up with the registered res_rd strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld_p <= '0;
    end else begin
      tag_vld_p[0] <= issue_vld;
      for (int i = 1; i < RD_LAT; i++) tag_vld_p[i] <= tag_vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_port_p[0] <= issue_port;
    for (int i = 1; i < RD_LAT; i++) tag_port_p[i] <= tag_port_p[i-1];
  end

  // Return stage: res_di captured in the cycle the last tag stage is valid
  always_ff @(posedge clk) begin
    if (reset) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= ret_vld && (ret_port == P0);
      p1_rvalid <= ret_vld && (ret_port == P1);
      if (ret_vld && (ret_port == P0)) p0_rdata <= res_di;
      if (ret_vld && (ret_port == P1)) p1_rdata <= res_di;
    end
  end

endmodule

// File: rtl/res_mem_arbiter.sv
// Two-port arbiter for the single-port result RAM with locked RMW support.
// Optional port-1 aging enabled by defining RES_ARB_AGING_EN.
module res_mem_arbiter
  import res_arb_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic          p0_lock,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic          p1_lock,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          res_rd,
  output logic          res_wr,
  output logic [AW-1:0] res_addr,
  output logic [DW-1:0] res_do,
  input  logic [DW-1:0] res_di,
  output logic          arb_lock_to
);

  localparam int LCW = $clog2(LOCK_MAX + 1);

  arb_state_e     state;
  logic [LCW-1:0] lock_cnt;
  logic           boost1;
  logic           force1;

  logic           gnt_any;
  logic           sel_port;
  logic           sel_we;
  logic           sel_lock;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;
  logic [LCW-1:0] held_nxt;
  logic           lock_hit;

`ifdef RES_ARB_AGING_EN
  localparam int WCW = $clog2(MAX_WAIT + 1);
  logic [WCW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (p1_gnt) begin
      wait_cnt <= '0;
    end else if (p1_req && (wait_cnt != WCW'(MAX_WAIT))) begin
      wait_cnt <= wait_cnt + WCW'(1);
    end
  end

  assign force1 = (wait_cnt == WCW'(MAX_WAIT)) && (state == IDLE);
`else
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT != 0);
  assign force1 = 1'b0;
`endif

  // boost1 gives port 1 the first turn right after port 0 loses a lock to
  // timeout, so the forced release actually hands the RAM over.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (p1_req && (force1 || boost1)) p1_gnt = 1'b1;
          else if (p0_req)                  p0_gnt = 1'b1;
          else if (p1_req)                  p1_gnt = 1'b1;
        end
        OWN0:    p0_gnt = p0_req;
        OWN1:    p1_gnt = p1_req;
        default: ;
      endcase
    end
  end

  assign gnt_any   = p0_gnt | p1_gnt;
  assign sel_port  = p1_gnt ? P1 : P0;
  assign sel_we    = p1_gnt ? p1_we    : p0_we;
  assign sel_lock  = p1_gnt ? p1_lock  : p0_lock;
  assign sel_addr  = p1_gnt ? p1_addr  : p0_addr;
  assign sel_wdata = p1_gnt ? p1_wdata : p0_wdata;

  assign held_nxt = (state == IDLE) ? LCW'(1) : lock_cnt + LCW'(1);
  assign lock_hit = sel_lock && (held_nxt >= LCW'(LOCK_MAX));

  // Issue stage: FSM, lock count and registered RAM drive
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lock_cnt    <= '0;
      boost1      <= 1'b0;
      arb_lock_to <= 1'b0;
      res_rd      <= 1'b0;
      res_wr      <= 1'b0;
      res_addr    <= '0;
      res_do      <= '0;
    end else begin
      arb_lock_to <= 1'b0;
      boost1      <= 1'b0;
      res_rd      <= gnt_any && !sel_we;
      res_wr      <= gnt_any && sel_we;
      if (gnt_any) begin
        res_addr <= sel_addr;
        res_do   <= sel_wdata;
        if (lock_hit) begin
          state       <= IDLE;
          lock_cnt    <= '0;
          arb_lock_to <= 1'b1;
          boost1      <= (sel_port == P0);
        end else if (sel_lock) begin
          state    <= (sel_port == P1) ? OWN1 : OWN0;
          lock_cnt <= held_nxt;
        end else begin
          state    <= IDLE;
          lock_cnt <= '0;
        end
      end else if (state != IDLE) begin
        // Owner dropped its request: release the lock.
        state    <= IDLE;
        lock_cnt <= '0;
      end
    end
  end

  res_arb_rdtag #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_rdtag (
    .clk        (clk),
    .reset      (reset),
    .issue_vld  (gnt_any && !sel_we),
    .issue_port (sel_port),
    .res_di     (res_di),
    .p0_rvalid  (p0_rvalid),
    .p0_rdata   (p0_rdata),
    .p1_rvalid  (p1_rvalid),
    .p1_rdata   (p1_rdata)
  );

endmodule

// File: tb/tb_res_mem_arbiter.sv
// Scoreboard bench for res_mem_arbiter: transaction-level reference model
// predicts grants, RAM strobes and tagged read returns.
module tb_res_mem_arbiter;

  localparam int AW       = 14;
  localparam int DW       = 8;
  localparam int RD_LAT   = 1;
  localparam int LOCK_MAX = 4;
  localparam int MAX_WAIT = 8;
`ifdef RES_ARB_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          p0_req, p0_we, p0_lock, p0_gnt, p0_rvalid;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic          res_rd, res_wr, arb_lock_to;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_do, res_di;

  res_mem_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .LOCK_MAX(LOCK_MAX), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do),
    .res_di(res_di), .arb_lock_to(arb_lock_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // RAM behind the pins: asynchronous read for RD_LAT=1, write on the edge.
  logic [DW-1:0] ram     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  always @(posedge clk) if (res_wr) ram[res_addr] = res_do;
  assign res_di = ram[res_addr];

  typedef struct {
    bit            we;
    bit            lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;
  typedef struct {
    int            cyc;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;
  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } rd_t;

  acc_t pq0[$], pq1[$];
  op_t  opq[$];
  rd_t  rq0[$], rq1[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: who holds the RAM and for how many locked accesses.
  int owner = -1;
  int held = 0;
  int wait1 = 0;
  int boost = -1;
  int lock_to_cyc = -1;
  int lt_seen = 0;
  bit rst_drv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic miss(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event did not match scoreboard (cycle %0d)", name, cyc);
  endtask

  task automatic push_acc(input int p, input bit we, input bit lock,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    acc_t a;
    a.we = we; a.lock = lock; a.addr = addr; a.wdata = wdata;
    if (p == 0) pq0.push_back(a); else pq1.push_back(a);
  endtask

  task automatic push_rand(input int p);
    push_acc(p, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
             AW'($urandom_range(64, 79)), DW'($urandom));
  endtask

  // One clock: drive requests, check grants against the model, advance the model.
  task automatic cycle();
    acc_t a0, a1, acc;
    bit   r0, r1, e0, e1;
    int   w, nb;
    op_t  op;
    rd_t  rd;
    @(negedge clk);
    r0 = (pq0.size() > 0) && !rst_drv;
    r1 = (pq1.size() > 0) && !rst_drv;
    if (r0) a0 = pq0[0];
    if (r1) a1 = pq1[0];
    reset   = rst_drv;
    p0_req  = r0;
    p1_req  = r1;
    if (r0) begin p0_we = a0.we; p0_lock = a0.lock; p0_addr = a0.addr; p0_wdata = a0.wdata; end
    if (r1) begin p1_we = a1.we; p1_lock = a1.lock; p1_addr = a1.addr; p1_wdata = a1.wdata; end
    #1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!rst_drv) begin
      if (owner < 0) begin
        if (r1 && ((AGING && wait1 == MAX_WAIT) || boost == 1)) e1 = 1'b1;
        else if (r0) e0 = 1'b1;
        else if (r1) e1 = 1'b1;
      end else if (owner == 0) e0 = r0;
      else e1 = r1;
    end
    chk("p0_gnt", p0_gnt, e0);
    chk("p1_gnt", p1_gnt, e1);
    if (rst_drv) begin
      owner = -1; held = 0; wait1 = 0; boost = -1; lock_to_cyc = -1;
      opq.delete(); rq0.delete(); rq1.delete();
    end else begin
      nb = -1;
      if (owner == 0 && !r0) begin owner = -1; held = 0; end
      if (owner == 1 && !r1) begin owner = -1; held = 0; end
      if (e0 || e1) begin
        w = e1 ? 1 : 0;
        acc = e1 ? a1 : a0;
        if (e1) void'(pq1.pop_front()); else void'(pq0.pop_front());
        op.cyc = cyc + 1; op.we = acc.we; op.addr = acc.addr; op.data = acc.wdata;
        opq.push_back(op);
        if (acc.we) begin
          ref_mem[acc.addr] = acc.wdata;
        end else begin
          rd.cyc = cyc + 1 + RD_LAT;
          rd.data = ref_mem[acc.addr];
          if (e1) rq1.push_back(rd); else rq0.push_back(rd);
        end
        if (acc.lock) begin
          held = (owner < 0) ? 1 : held + 1;
          if (held >= LOCK_MAX) begin
            owner = -1; held = 0; lock_to_cyc = cyc + 1; nb = 1 - w;
          end else owner = w;
        end else begin
          owner = -1; held = 0;
        end
      end
      if (e1) wait1 = 0;
      else if (r1 && wait1 < MAX_WAIT) wait1++;
      boost = nb;
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe or return.
  always @(negedge clk) begin : mon
    op_t op;
    rd_t rd;
    if (res_rd || res_wr) begin
      if (opq.size() == 0) miss("spurious_ram_strobe");
      else begin
        op = opq.pop_front();
        chk("ram_cycle", cyc, op.cyc);
        chk("ram_wr", res_wr, op.we);
        chk("ram_rd", res_rd, !op.we);
        chk("ram_addr", res_addr, op.addr);
        chk("ram_do", res_do, op.data);
      end
    end else if (opq.size() > 0 && opq[0].cyc <= cyc) begin
      miss("missing_ram_strobe");
      void'(opq.pop_front());
    end
    if (p0_rvalid) begin
      if (rq0.size() == 0) miss("spurious_p0_rvalid");
      else begin
        rd = rq0.pop_front();
        chk("p0_rvalid_cycle", cyc, rd.cyc);
        chk("p0_rdata", p0_rdata, rd.data);
      end
    end else if (rq0.size() > 0 && rq0[0].cyc <= cyc) begin
      miss("missing_p0_rvalid");
      void'(rq0.pop_front());
    end
    if (p1_rvalid) begin
      if (rq1.size() == 0) miss("spurious_p1_rvalid");
      else begin
        rd = rq1.pop_front();
        chk("p1_rvalid_cycle", cyc, rd.cyc);
        chk("p1_rdata", p1_rdata, rd.data);
      end
    end else if (rq1.size() > 0 && rq1[0].cyc <= cyc) begin
      miss("missing_p1_rvalid");
      void'(rq1.pop_front());
    end
    if (arb_lock_to || lock_to_cyc == cyc) chk("arb_lock_to", arb_lock_to, lock_to_cyc == cyc);
    if (arb_lock_to) lt_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = DW'(i * 37 + 11);
      ref_mem[i] = DW'(i * 37 + 11);
    end
    ram[129] = 8'h03;
    ref_mem[129] = 8'h03;
    reset = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_lock = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_lock = 1'b0; p1_addr = '0; p1_wdata = '0;
    rst_drv = 1'b1;
    repeat (3) cycle();
    chk("rst_res_rd", res_rd, 0);
    chk("rst_res_wr", res_wr, 0);
    chk("rst_res_addr", res_addr, 0);
    chk("rst_res_do", res_do, 0);
    chk("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
    chk("rst_rdata", {p0_rdata, p1_rdata}, 0);
    chk("rst_lock_to", arb_lock_to, 0);
    rst_drv = 1'b0;
    cycle();

    // p0 read of a preset location
    push_acc(0, 1'b0, 1'b0, 14'd129, 8'h00);
    cycle();
    chk("t1_p0_gnt", p0_gnt, 1);
    repeat (2) cycle();
    chk("t1_p0_rdata", p0_rdata, 8'h03);

    // Simultaneous writes: p0 first, p1 the following cycle
    push_acc(0, 1'b1, 1'b0, 14'd200, 8'h01);
    push_acc(1, 1'b1, 1'b0, 14'd300, 8'h02);
    cycle();
    chk("t2_p0_first", {p0_gnt, p1_gnt}, 2'b10);
    cycle();
    chk("t2_p1_second", {p0_gnt, p1_gnt}, 2'b01);
    repeat (3) cycle();
    chk("t2_ram200", ram[200], 8'h01);
    chk("t2_ram300", ram[300], 8'h02);

    // p1 locked RMW holds off a requesting p0
    push_acc(1, 1'b0, 1'b1, 14'd16253, 8'h00);
    push_acc(1, 1'b1, 1'b0, 14'd16253, 8'h5a);
    cycle();
    chk("t3_p1_read_gnt", p1_gnt, 1);
    push_acc(0, 1'b0, 1'b0, 14'd16253, 8'h00);
    cycle();
    chk("t3_p0_blocked", {p0_gnt, p1_gnt}, 2'b01);
    cycle();
    chk("t3_p0_after", {p0_gnt, p1_gnt}, 2'b10);
    repeat (4) cycle();

    // p0 lock chain hits LOCK_MAX, p1 gets the released RAM
    for (int i = 0; i < 6; i++) push_acc(0, 1'b0, 1'b1, AW'(400 + i), 8'h00);
    push_acc(1, 1'b0, 1'b0, 14'd500, 8'h00);
    got = lt_seen;
    for (int i = 0; i < LOCK_MAX; i++) begin
      cycle();
      chk("t4_p0_locked_gnt", {p0_gnt, p1_gnt}, 2'b10);
    end
    cycle();
    chk("t4_p1_after_to", {p0_gnt, p1_gnt}, 2'b01);
    chk("t4_lock_to_high", arb_lock_to, 1);
    repeat (6) cycle();
    chk("t4_lock_to_count", lt_seen - got, 1);

    // Port-1 starvation / aging under continuous p0 traffic
    rst_drv = 1'b1;
    cycle();
    rst_drv = 1'b0;
    for (int i = 0; i < 30; i++) push_acc(0, 1'b0, 1'b0, AW'(64 + (i % 8)), 8'h00);
    push_acc(1, 1'b0, 1'b0, 14'd70, 8'h00);
    got = -1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (p1_gnt && got < 0) got = k;
    end
`ifdef RES_ARB_AGING_EN
    chk("t5_aging_gnt_cycle", got, 8);
`else
    chk("t5_starved", got, -1);
`endif
    repeat (20) cycle();

    // Reset right after a p1 read grant drops the return
    push_acc(1, 1'b0, 1'b0, 14'd16253, 8'h00);
    cycle();
    chk("t6_p1_gnt", p1_gnt, 1);
    rst_drv = 1'b1;
    cycle();
    rst_drv = 1'b0;
    cycle();
    chk("t6_res_rd", res_rd, 0);
    chk("t6_res_wr", res_wr, 0);
    chk("t6_res_addr", res_addr, 0);
    chk("t6_res_do", res_do, 0);
    chk("t6_p1_rvalid", p1_rvalid, 0);
    repeat (4) cycle();

    // Randomized mixed traffic
    for (int k = 0; k < 800; k++) begin
      if (pq0.size() < 2 && $urandom_range(0, 9) < 6) push_rand(0);
      if (pq1.size() < 2 && $urandom_range(0, 9) < 4) push_rand(1);
      cycle();
    end
    pq0.delete();
    pq1.delete();
    repeat (10) cycle();
    chk("drain_ops", opq.size(), 0);
    chk("drain_rq0", rq0.size(), 0);
    chk("drain_rq1", rq1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
